// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor; master drives operands, slave computes.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b - bin), LSB first, one bit per clock,
// framed by valid/ready handshakes on operands and result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave s
);
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic [WIDTH-1:0] w_diff_next;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_release;
  logic             w_last;

  full_subtractor u_fs (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_accept  = (r_state == ST_IDLE) && s.in_valid;
  assign w_release = (r_state == ST_DONE) && s.out_ready;
  assign w_last    = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_diff_next = w_d;
    end else begin : g_wn
      assign w_diff_next = {w_d, r_diff_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (w_release) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s.in_ready  = (r_state == ST_IDLE);
    s.out_valid = (r_state == ST_DONE);
    s.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  end

  // Result registers load only on the final RUN edge, so diff/bout stay put
  // through DONE stalls and after the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
    end else if (w_accept) begin
      r_a_sr    <= s.a;
      r_b_sr    <= s.b;
      r_diff_sr <= '0;
      r_borrow  <= s.bin;
      r_cnt     <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_diff_sr <= w_diff_next;
      r_borrow  <= w_bo;
      r_cnt     <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff <= w_diff_next;
        r_bout <= w_bo;
      end
    end
  end

  assign s.diff = r_diff;
  assign s.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor against an arithmetic a-b-bin model.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(8)) u ();
  serial_subtractor_if #(.WIDTH(1)) v ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .s(u));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .s(v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: plain modular subtraction and an unsigned compare for the borrow.
  function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return 8'(r & 255);
  endfunction

  function automatic logic ref_bout(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return int'(a) < (int'(b) + int'(bin));
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int stall, input bit poke);
    int k;
    int lat;
    logic [7:0] ed;
    logic       eb;
    k = 0;
    while (!u.in_ready && k < 20) begin
      tick();
      k++;
    end
    check("in_ready_before_op", u.in_ready, 1);
    u.in_valid = 1'b1;
    u.a = a;
    u.b = b;
    u.bin = bin;
    tick();
    u.in_valid = 1'b0;
    u.a = 8'($urandom);
    u.b = 8'($urandom);
    u.bin = 1'($urandom);
    lat = 0;
    while (!u.out_valid && lat < 40) begin
      if (poke && lat == 3) begin
        u.in_valid = 1'b1;
        u.a = 8'h11;
        check("in_ready_in_run", u.in_ready, 0);
      end else begin
        u.in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    u.in_valid = 1'b0;
    ed = ref_diff(a, b, bin);
    eb = ref_bout(a, b, bin);
    check("latency", lat, 8);
    check("diff", u.diff, ed);
    check("bout", u.bout, eb);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_out_valid", u.out_valid, 1);
      check("stall_in_ready", u.in_ready, 0);
      check("stall_diff", u.diff, ed);
      check("stall_bout", u.bout, eb);
    end
    u.out_ready = 1'b1;
    tick();
    u.out_ready = 1'b0;
    check("in_ready_after_hs", u.in_ready, 1);
    check("out_valid_after_hs", u.out_valid, 0);
    check("diff_held", u.diff, ed);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    u.in_valid = 1'b0; u.a = '0; u.b = '0; u.bin = 1'b0; u.out_ready = 1'b0;
    v.in_valid = 1'b0; v.a = '0; v.b = '0; v.bin = 1'b0; v.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", u.in_ready, 1);
    check("rst_out_valid", u.out_valid, 0);
    check("rst_busy", u.busy, 0);
    check("rst_diff", u.diff, 0);
    check("rst_bout", u.bout, 0);
    rst = 1'b0;
    tick();

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
    run_op(8'hA7, 8'h3C, 1'b0, 5, 1'b1);

    // Abort mid-RUN: rst sampled on the 3rd RUN edge.
    u.in_valid = 1'b1; u.a = 8'hC3; u.b = 8'h21; u.bin = 1'b0;
    tick();
    u.in_valid = 1'b0;
    tick();
    tick();
    check("busy_mid_run", u.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", u.out_valid, 0);
    check("abort_in_ready", u.in_ready, 1);
    check("abort_busy", u.busy, 0);
    check("abort_diff", u.diff, 0);
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b0);

    for (int n = 0; n < 100; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    v.in_valid = 1'b1; v.a = 1'b0; v.b = 1'b1; v.bin = 1'b0;
    tick();
    v.in_valid = 1'b0;
    lat = 0;
    while (!v.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("w1_latency", lat, 1);
    check("w1_diff", v.diff, 1);
    check("w1_bout", v.bout, 1);
    v.out_ready = 1'b1;
    tick();
    v.out_ready = 1'b0;
    check("w1_in_ready_after_hs", v.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
